// File: rtl/conv_window_feeder_if.sv
// Column-feeder bus: row-FIFO side, shift-register side and band control.
// The slave modport is the feeder; the master modport is its environment.
`ifndef WID_FIFO
`define WID_FIFO 8
`endif

interface conv_window_feeder_if #(
    parameter int DATA_W = `WID_FIFO,
    parameter int COL_W  = 6
);
    logic              start;
    logic [COL_W-1:0]  row_len;
    logic              stall;
    logic              fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic [DATA_W-1:0] fifo_data_0, fifo_data_1, fifo_data_2;
    logic              fifo_rd;
    logic              shifting;
    logic [DATA_W-1:0] inp_sr_0, inp_sr_1, inp_sr_2;
    logic              win_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, row_len, stall,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output fifo_data_0, fifo_data_1, fifo_data_2,
        input  fifo_rd, shifting, inp_sr_0, inp_sr_1, inp_sr_2,
        input  win_valid, busy, done
    );

    modport slave (
        input  start, row_len, stall,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  fifo_data_0, fifo_data_1, fifo_data_2,
        output fifo_rd, shifting, inp_sr_0, inp_sr_1, inp_sr_2,
        output win_valid, busy, done
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Pops one three-row column per cycle from FWFT row FIFOs into the convolver shift
// registers and flags full 3x3 windows. Define CONV_FEEDER_ZERO_PAD_EN for one zero column each side.
`ifndef WID_FIFO
`define WID_FIFO 8
`endif

module conv_window_feeder #(
    parameter int DATA_W = `WID_FIFO,
    parameter int IMG_W  = 32,
    parameter int COL_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    conv_window_feeder_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            r_state, w_state_nxt;
    logic [COL_W-1:0]  r_len, r_pop_cnt, r_sh_cnt, w_total;
    logic              w_len_ok, w_start_ok, w_fifo_ok;
    logic              w_issue, w_pop, w_last_issue, w_final;
    logic              r_vld_p1, r_win_vld_p2, r_bad_done;
    logic [DATA_W-1:0] r_sr_0_p1, r_sr_1_p1, r_sr_2_p1;
`ifdef CONV_FEEDER_ZERO_PAD_EN
    logic              r_lead_done;
`endif

    assign w_len_ok   = (bus.row_len >= COL_W'(3)) && (bus.row_len <= COL_W'(IMG_W));
    assign w_start_ok = (r_state == S_IDLE) && bus.start && w_len_ok;
    assign w_fifo_ok  = !bus.fifo_empty_0 && !bus.fifo_empty_1 && !bus.fifo_empty_2;
`ifdef CONV_FEEDER_ZERO_PAD_EN
    assign w_total    = r_len + COL_W'(2);
`else
    assign w_total    = r_len;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_pop        = 1'b0;
        w_last_issue = 1'b0;
        w_final      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!bus.stall) begin
`ifdef CONV_FEEDER_ZERO_PAD_EN
                    if (!r_lead_done) begin
                        w_issue = 1'b1;
                    end else if (r_pop_cnt < r_len) begin
                        w_issue = w_fifo_ok;
                        w_pop   = w_fifo_ok;
                    end else begin
                        w_issue      = 1'b1;
                        w_last_issue = 1'b1;
                    end
`else
                    if (w_fifo_ok && (r_pop_cnt < r_len)) begin
                        w_issue      = 1'b1;
                        w_pop        = 1'b1;
                        w_last_issue = (r_pop_cnt == r_len - COL_W'(1));
                    end
`endif
                end
                if (w_last_issue) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // the band ends on the window produced by its final shift
                if (r_win_vld_p2 && (r_sh_cnt == w_total)) begin
                    w_final     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_pop_cnt    <= '0;
            r_sh_cnt     <= '0;
            r_bad_done   <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_win_vld_p2 <= 1'b0;
            r_sr_0_p1    <= '0;
            r_sr_1_p1    <= '0;
            r_sr_2_p1    <= '0;
`ifdef CONV_FEEDER_ZERO_PAD_EN
            r_lead_done  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_bad_done <= (r_state == S_IDLE) && bus.start && !w_len_ok;
            if (w_start_ok) begin
                r_len     <= bus.row_len;
                r_pop_cnt <= '0;
                r_sh_cnt  <= '0;
            end else begin
                if (w_pop)    r_pop_cnt <= r_pop_cnt + COL_W'(1);
                if (r_vld_p1) r_sh_cnt  <= r_sh_cnt + COL_W'(1);
            end
`ifdef CONV_FEEDER_ZERO_PAD_EN
            if (w_start_ok)    r_lead_done <= 1'b0;
            else if (w_issue)  r_lead_done <= 1'b1;
`endif
            // stage p1: issued column, pads carry zeros
            r_vld_p1 <= w_issue;
            if (w_issue) begin
                r_sr_0_p1 <= w_pop ? bus.fifo_data_0 : '0;
                r_sr_1_p1 <= w_pop ? bus.fifo_data_1 : '0;
                r_sr_2_p1 <= w_pop ? bus.fifo_data_2 : '0;
            end
            // stage p2: third and later shifts complete a window
            r_win_vld_p2 <= r_vld_p1 && (r_sh_cnt >= COL_W'(2));
        end
    end

    assign bus.fifo_rd   = w_pop;
    assign bus.shifting  = r_vld_p1;
    assign bus.inp_sr_0  = r_sr_0_p1;
    assign bus.inp_sr_1  = r_sr_1_p1;
    assign bus.inp_sr_2  = r_sr_2_p1;
    assign bus.win_valid = r_win_vld_p2;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_bad_done | w_final;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: table-driven bands, hand-written corner sequences and
// random bands, all checked per cycle against an event-scheduling reference model.
module tb_conv_window_feeder;
    localparam int DW = 8;
    localparam int IW = 32;
    localparam int CW = 6;
`ifdef CONV_FEEDER_ZERO_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_feeder_if #(.DATA_W(DW), .COL_W(CW)) bus ();
    conv_window_feeder #(.DATA_W(DW), .IMG_W(IW), .COL_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // environment: three FWFT row FIFOs
    logic [DW-1:0] fq0[$], fq1[$], fq2[$];
    bit hold_empty1;

    // reference model: a band is a list of issues; each issue schedules a shift one
    // cycle later and, from the third issue on, a window two cycles later
    bit              m_busy;
    int              m_total, m_issued, m_pops, m_done_at, m_bad_at, m_win_idx;
    int              ev_sh_t[$];
    logic [3*DW-1:0] ev_sh_d[$];
    int              ev_win_t[$];
    logic [3*DW-1:0] m_inp;
    logic [3*DW-1:0] m_cols[$];
    logic [3*DW-1:0] taps[3];
    int              n_rd, n_sh, n_win, n_done;

    typedef struct {
        int len;
        int stall_at;
        int stall_n;
        int empty_at;
        int empty_n;
        int exp_pops;
        int exp_shifts;
        int exp_wins;
    } vec_t;
    vec_t vt[9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_total = 0; m_issued = 0; m_pops = 0;
        m_done_at = -1; m_bad_at = -1; m_win_idx = 0;
        ev_sh_t.delete(); ev_sh_d.delete(); ev_win_t.delete(); m_cols.delete();
        m_inp = '0;
    endtask

    task automatic push_col(input int c);
        fq0.push_back(DW'(c));
        fq1.push_back(DW'(c + 64));
        fq2.push_back(DW'(c + 128));
    endtask

    task automatic flush();
        fq0.delete(); fq1.delete(); fq2.delete();
    endtask

    task automatic drive_fifo();
        bus.fifo_empty_0 = (fq0.size() == 0);
        bus.fifo_empty_1 = (fq1.size() == 0) || hold_empty1;
        bus.fifo_empty_2 = (fq2.size() == 0);
        bus.fifo_data_0  = (fq0.size() != 0) ? fq0[0] : '0;
        bus.fifo_data_1  = (fq1.size() != 0) ? fq1[0] : '0;
        bus.fifo_data_2  = (fq2.size() != 0) ? fq2[0] : '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_rd"},   128'(bus.fifo_rd),   128'(0));
        check({tag, "_shifting"},  128'(bus.shifting),  128'(0));
        check({tag, "_inp_sr"},    128'({bus.inp_sr_2, bus.inp_sr_1, bus.inp_sr_0}), 128'(0));
        check({tag, "_win_valid"}, 128'(bus.win_valid), 128'(0));
        check({tag, "_busy"},      128'(bus.busy),      128'(0));
        check({tag, "_done"},      128'(bus.done),      128'(0));
    endtask

    // one clock cycle: inputs applied at the falling edge, outputs checked 1 unit later
    task automatic step();
        bit pad, iss, exp_sh, exp_win, exp_done, take, rd;
        logic [3*DW-1:0] col, exp_inp, d;
        drive_fifo();
        #1;
        pad = (PAD != 0) && ((m_issued == 0) || (m_issued == m_total - 1));
        iss = m_busy && (m_issued < m_total) && !bus.stall &&
              (pad || (!bus.fifo_empty_0 && !bus.fifo_empty_1 && !bus.fifo_empty_2));
        col = pad ? '0 : {bus.fifo_data_2, bus.fifo_data_1, bus.fifo_data_0};
        exp_sh   = (ev_sh_t.size() != 0) && (ev_sh_t[0] == cyc);
        exp_inp  = exp_sh ? ev_sh_d[0] : m_inp;
        exp_win  = (ev_win_t.size() != 0) && (ev_win_t[0] == cyc);
        exp_done = (m_done_at == cyc) || (m_bad_at == cyc);

        check("fifo_rd",   128'(bus.fifo_rd),   128'(iss && !pad));
        check("shifting",  128'(bus.shifting),  128'(exp_sh));
        check("inp_sr",    128'({bus.inp_sr_2, bus.inp_sr_1, bus.inp_sr_0}), 128'(exp_inp));
        check("win_valid", 128'(bus.win_valid), 128'(exp_win));
        check("busy",      128'(bus.busy),      128'(m_busy));
        check("done",      128'(bus.done),      128'(exp_done));
        if (exp_win && bus.win_valid) begin
            if (m_cols.size() >= m_win_idx + 3)
                check("window", 128'({taps[2], taps[1], taps[0]}),
                      128'({m_cols[m_win_idx], m_cols[m_win_idx+1], m_cols[m_win_idx+2]}));
            m_win_idx++;
        end

        if (exp_sh) begin
            m_inp = ev_sh_d.pop_front();
            void'(ev_sh_t.pop_front());
        end
        if (exp_win) void'(ev_win_t.pop_front());
        if (iss) begin
            ev_sh_t.push_back(cyc + 1);
            ev_sh_d.push_back(col);
            m_cols.push_back(col);
            if (m_issued >= 2) ev_win_t.push_back(cyc + 2);
            if (m_issued == m_total - 1) m_done_at = cyc + 2;
            m_issued++;
            if (!pad) m_pops++;
        end
        if (bus.start && !m_busy) begin
            if ((int'(bus.row_len) >= 3) && (int'(bus.row_len) <= IW)) begin
                m_busy = 1; m_total = int'(bus.row_len) + 2 * PAD;
                m_issued = 0; m_pops = 0; m_win_idx = 0; m_cols.delete();
            end else begin
                m_bad_at = cyc + 1;
            end
        end
        if (m_done_at == cyc) begin
            m_busy = 0;
            m_done_at = -1;
        end

        n_rd   += int'(bus.fifo_rd);
        n_sh   += int'(bus.shifting);
        n_win  += int'(bus.win_valid);
        n_done += int'(bus.done);
        take = bus.shifting;
        rd   = bus.fifo_rd;
        d    = {bus.inp_sr_2, bus.inp_sr_1, bus.inp_sr_0};
        @(posedge clk);
        if (rd) begin
            if (fq0.size() != 0) void'(fq0.pop_front());
            if (fq1.size() != 0) void'(fq1.pop_front());
            if (fq2.size() != 0) void'(fq2.pop_front());
        end
        if (take) begin
            taps[2] = taps[1];
            taps[1] = taps[0];
            taps[0] = d;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_band(input int len, input int st_at, input int st_n,
                            input int em_at, input int em_n,
                            input int rs_at, input bit rs_done, input bit rnd);
        int  stall_left, empty_left, guard, p0, p1, p2;
        bit  st_used, em_used, legal;
        stall_left = 0; empty_left = 0; guard = 0; p0 = 0; p1 = 0; p2 = 0;
        st_used = 0; em_used = 0;
        legal = (len >= 3) && (len <= IW);
        n_rd = 0; n_sh = 0; n_win = 0; n_done = 0;
        bus.row_len = CW'(len);
        bus.stall = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while ((m_busy || (m_bad_at >= cyc)) && (guard < 600)) begin
            if (!st_used && (m_pops == st_at)) begin st_used = 1; stall_left = st_n; end
            if (!em_used && (m_pops == em_at)) begin em_used = 1; empty_left = em_n; end
            bus.stall   = rnd ? ($urandom_range(0, 3) == 0) : (stall_left > 0);
            hold_empty1 = (empty_left > 0);
            if (stall_left > 0) stall_left--;
            if (empty_left > 0) empty_left--;
            if (rnd && legal) begin
                if ((p0 < len) && ($urandom_range(0, 1) == 1)) begin fq0.push_back(DW'($urandom)); p0++; end
                if ((p1 < len) && ($urandom_range(0, 1) == 1)) begin fq1.push_back(DW'($urandom)); p1++; end
                if ((p2 < len) && ($urandom_range(0, 1) == 1)) begin fq2.push_back(DW'($urandom)); p2++; end
            end
            bus.start   = (guard == rs_at) || (rs_done && (m_done_at == cyc));
            bus.row_len = (guard == rs_at) ? CW'(3) : (bus.start ? CW'(4) : CW'(len));
            step();
            bus.start = 1'b0;
            guard++;
        end
        bus.stall   = 1'b0;
        hold_empty1 = 1'b0;
        check("band_timeout", 128'(guard < 600), 128'(1));
        step();
        step();
    endtask

    task automatic check_band(input string tag, input int pops, input int shifts, input int wins);
        check({tag, "_pops"},   128'(n_rd),   128'(pops));
        check({tag, "_shifts"}, 128'(n_sh),   128'(shifts));
        check({tag, "_wins"},   128'(n_win),  128'(wins));
        check({tag, "_done"},   128'(n_done), 128'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        //         len stall    empty    pops shifts      wins
        vt[0] = '{5,  -1, 0,   -1, 0,   5,   5 + 2*PAD,  3 + 2*PAD};
        vt[1] = '{4,   2, 3,   -1, 0,   4,   4 + 2*PAD,  2 + 2*PAD};
        vt[2] = '{6,  -1, 0,    3, 4,   6,   6 + 2*PAD,  4 + 2*PAD};
        vt[3] = '{2,  -1, 0,   -1, 0,   0,   0,          0};
        vt[4] = '{3,  -1, 0,   -1, 0,   3,   3 + 2*PAD,  1 + 2*PAD};
        vt[5] = '{32, -1, 0,   -1, 0,   32,  32 + 2*PAD, 30 + 2*PAD};
        vt[6] = '{33, -1, 0,   -1, 0,   0,   0,          0};
        vt[7] = '{0,  -1, 0,   -1, 0,   0,   0,          0};
        vt[8] = '{7,   0, 2,    6, 2,   7,   7 + 2*PAD,  5 + 2*PAD};

        rst = 1'b1;
        hold_empty1 = 1'b0;
        bus.start = 1'b0; bus.row_len = '0; bus.stall = 1'b0;
        taps[0] = '0; taps[1] = '0; taps[2] = '0;
        model_reset();
        drive_fifo();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            for (int c = 1; (c <= vt[i].len) && (c <= 40); c++) push_col(c);
            run_band(vt[i].len, vt[i].stall_at, vt[i].stall_n,
                     vt[i].empty_at, vt[i].empty_n, -1, 1'b0, 1'b0);
            check_band("vec", vt[i].exp_pops, vt[i].exp_shifts, vt[i].exp_wins);
            flush();
        end

        // start during a band, and in the band's done cycle, must both be ignored
        for (int c = 1; c <= 9; c++) push_col(c);
        run_band(5, -1, 0, -1, 0, 3, 1'b1, 1'b0);
        check_band("restart", 5, 5 + 2*PAD, 3 + 2*PAD);
        check("restart_leftover", 128'(fq0.size()), 128'(4));
        flush();

        // asynchronous reset two pops into a band; leftover columns feed the next band
        for (int c = 1; c <= 6; c++) push_col(c);
        bus.row_len = CW'(6);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int g = 0; (g < 20) && (m_pops < 2); g++) step();
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        run_band(3, -1, 0, -1, 0, -1, 1'b0, 1'b0);
        check_band("after_rst", 3, 3 + 2*PAD, 1 + 2*PAD);
        flush();

        for (int b = 0; b < 8; b++) begin
            int len, sel;
            bit legal;
            sel = $urandom_range(0, 9);
            if (sel == 0)      len = $urandom_range(0, 2);
            else if (sel == 1) len = $urandom_range(33, 63);
            else               len = $urandom_range(3, IW);
            legal = (len >= 3) && (len <= IW);
            run_band(len, -1, 0, -1, 0, -1, 1'b0, 1'b1);
            check_band("rand", legal ? len : 0, legal ? len + 2*PAD : 0,
                       legal ? len - 2 + 2*PAD : 0);
            flush();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Drives the three-row column shift registers of the convolver. Pops one column (three row pixels) per cycle from three first-word-fall-through row FIFOs and presents it as `inp_sr_*` with a `shifting` strobe. It tracks columns per row band and flags `win_valid` when the registers hold a complete 3x3 window for the MAC array.

## Interface
- `DATA_W`, default `` `WID_FIFO ``: pixel width. Matches the shift-register data width.
- `IMG_W`, default 32: maximum columns per band.
- `COL_W`, default 6: width of `row_len` and the internal counters. Must satisfy 2^COL_W > IMG_W+2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a band. Ignored while `busy`=1.
- `row_len` in COL_W: columns in the band. Sampled on the accepted `start`. Legal range is 3..IMG_W.
- `stall` in 1: downstream not ready. Blocks new column issue.
- `fifo_empty_0/1/2` in 1: row FIFO empty flags.
- `fifo_data_0/1/2` in DATA_W: FWFT head data.
- `fifo_rd` out 1: pops all three FIFOs in the same cycle.
- `shifting` out 1: shift enable to the three shift registers.
- `inp_sr_0/1/2` out DATA_W: column data to shift registers 0/1/2.
- `win_valid` out 1: the shift-register outputs hold a full window this cycle.
- `busy` out 1: a band is in progress.
- `done` out 1: one-cycle pulse marking the end of the band.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** on `start`=1 with 3 ≤ `row_len` ≤ IMG_W. On entry, latch `row_len`, clear `pop_cnt` and `sh_cnt`, and set `busy`=1.
- **Illegal `row_len`:** a `start` with `row_len` outside 3..IMG_W stays in IDLE and pulses `done` on the next cycle. No pops, no shifts.
- **Issue condition in RUN** (at most one issue per cycle):
  - Pop issue: `stall`=0, all three `fifo_empty_*`=0, and `pop_cnt` < `row_len`.
  - Pop issue drives combinational `fifo_rd`=1, captures `fifo_data_*`, and increments `pop_cnt`.
  - Pad issue (macro only, see Configuration): requires `stall`=0 only. Does not assert `fifo_rd`.
- **Data path:** an issue at cycle t gives a registered `shifting`=1 with `inp_sr_*` = captured data at t+1. With no issue at t, `shifting`=0 at t+1 and `inp_sr_*` hold their value.
- **Shift counting:** `sh_cnt` increments on every `shifting` pulse.
  - `win_valid` is registered: it equals 1 in the cycle after a `shifting` pulse that raised `sh_cnt` to ≥3. Otherwise 0.
- **RUN → DRAIN:** when the last issue of the band occurs.
- **DRAIN → IDLE:** when the final `win_valid` is asserted. `done`=1 in that same cycle. `busy`=0 from the following cycle.
- **Stall scope:** `stall` blocks issue only. A column already issued always completes its `shifting` and `win_valid` sequence.
- **Empty FIFOs in RUN:** the block waits indefinitely. It has no timeout.
- **Count per band:** exactly `row_len` pops; window count is given under Configuration.

## Timing
- **Reset values:** `fifo_rd`=0, `shifting`=0, `inp_sr_*`=0, `win_valid`=0, `busy`=0, `done`=0; state=IDLE; counters=0.
- **Reset mid-band:** everything returns to the reset values immediately. Unread FIFO contents are left untouched.
- **`start` latency:** `start` at cycle s makes the first issue possible at s+1.
- **Per-column latency:** issue at t, `shifting` at t+1, shift registers update at the t+2 edge, `win_valid` at t+2.
- **Throughput:** one column per cycle when the FIFOs are non-empty and `stall`=0.
- **Same-cycle `start` and `done`:** `start` is ignored, because `busy` is still 1.

## Configuration
- **Macro:** `CONV_FEEDER_ZERO_PAD_EN`.
- **When defined:**
  - One pad column (`inp_sr_*`=0, no pop) is issued first.
  - The `row_len` pop issues follow.
  - One trailing pad column is issued last.
  - Total shifts = `row_len`+2; windows = `row_len` ("same" horizontal padding).
- **When undefined:**
  - No pads are issued.
  - Total shifts = `row_len`; windows = `row_len`−2 ("valid" convolution).

## Test plan
- **Basic band:** reset, then `row_len`=5 with the FIFOs preloaded with columns 1..5, `stall`=0.
  - 5 consecutive `fifo_rd`, `shifting` on 5 consecutive cycles.
  - `win_valid` on 3 cycles, with outputs (3,2,1), (4,3,2), (5,4,3) at registers 1/2/3.
  - `done` on the third `win_valid`.
- **Stall:** `row_len`=4, `stall`=1 for 3 cycles after the second pop.
  - No `fifo_rd` during the stall; the in-flight shift completes.
  - Still exactly 4 pops and 2 `win_valid`.
- **FIFO starvation:** `fifo_empty_1`=1 for 4 cycles mid-band.
  - `fifo_rd` held 0 throughout; resumes when the flag clears; `busy` stays 1.
- **Illegal length and ignored restart:**
  - `row_len`=2: `done` next cycle, zero pops, `busy` never 1.
  - `start` while `busy`: ignored, and `row_len` is not relatched.
- **Reset mid-band:** assert `rst` after 2 pops.
  - All outputs 0 in the same cycle.
  - A following `start` with `row_len`=3 yields 1 window.
- **`CONV_FEEDER_ZERO_PAD_EN` defined, `row_len`=3:**
  - 5 shifts, first and last with `inp_sr_*`=0.
  - 3 pops and 3 `win_valid`.
